// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging N valid/ready streams onto one registered output stream.
// Define STREAM_ARB_PKT_LOCK_EN to hold the grant until i_last; otherwise arbitration is per beat.
module stream_rr_arbiter #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    localparam int IDX_W     = ($clog2(N) > 0) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N-1:0]            i_valid,
    output logic [N-1:0]            i_ready,
    input  logic [N*DATA_WIDTH-1:0] i_data,
    input  logic [N-1:0]            i_last,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_last,
    output logic [IDX_W-1:0]        o_grant
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cur;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] ptr_next;
    logic             lock;
    logic             sel_found;
    logic             load_ok;
    logic             xfer;
    logic             end_pkt;
    int               scan_idx;

    assign load_ok = !o_valid || o_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        scan_idx  = 0;
        if (lock) begin
            sel       = cur;
            sel_found = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                scan_idx = int'(ptr) + i;
                if (scan_idx >= N) begin
                    scan_idx = scan_idx - N;
                end
                if (!sel_found && i_valid[scan_idx]) begin
                    sel       = IDX_W'(scan_idx);
                    sel_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        i_ready = '0;
        if (!reset && load_ok && sel_found) begin
            i_ready[sel] = 1'b1;
        end
    end

    assign xfer     = !reset && load_ok && sel_found && i_valid[sel];
    assign ptr_next = (sel == IDX_W'(N - 1)) ? '0 : sel + 1'b1;

`ifdef STREAM_ARB_PKT_LOCK_EN
    assign end_pkt = i_last[sel];
`else
    // Beat-level round-robin: every beat closes its "packet" for arbitration only.
    assign end_pkt = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_grant <= '0;
            lock    <= 1'b0;
            cur     <= '0;
            ptr     <= '0;
        end else if (xfer) begin
            o_valid <= 1'b1;
            o_data  <= i_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            o_last  <= i_last[sel];
            o_grant <= sel;
            if (end_pkt) begin
                lock <= 1'b0;
                ptr  <= ptr_next;
            end else begin
                lock <= 1'b1;
                cur  <= sel;
            end
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

`ifdef FORMAL
    // A requester that has raised valid keeps valid, data and last steady until accepted.
    for (genvar k = 0; k < N; k++) begin : g_upstream_stable
        assume property (@(posedge clk) disable iff (reset)
            i_valid[k] && !i_ready[k] |=>
                i_valid[k] && $stable(i_data[k*DATA_WIDTH +: DATA_WIDTH]) && $stable(i_last[k]));
    end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed testbench for stream_rr_arbiter (N=4, 8-bit data); expectations follow the
// STREAM_ARB_PKT_LOCK_EN setting of the build.
module tb_stream_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  i_valid;
    logic [3:0]  i_ready;
    logic [31:0] i_data;
    logic [3:0]  i_last;
    logic        o_valid;
    logic        o_ready;
    logic [7:0]  o_data;
    logic        o_last;
    logic [1:0]  o_grant;

    int n_checks = 0;
    int n_errors = 0;

    stream_rr_arbiter #(.N(4), .DATA_WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_grant (o_grant)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        i_valid = '0;
        i_last  = '0;
        i_data  = '0;
        o_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Apply inputs, check i_ready before the edge, then check the registered output after it.
    task automatic step(input string tag, input logic [3:0] v, input logic [3:0] last,
                        input logic [31:0] d, input logic [3:0] rdy, input logic ov,
                        input logic [7:0] od, input logic ol, input logic [1:0] og);
        i_valid = v;
        i_last  = last;
        i_data  = d;
        #1;
        check({tag, ".i_ready"}, 32'(i_ready), 32'(rdy));
        tick();
        check({tag, ".o_valid"}, 32'(o_valid), 32'(ov));
        check({tag, ".o_data"},  32'(o_data),  32'(od));
        check({tag, ".o_last"},  32'(o_last),  32'(ol));
        check({tag, ".o_grant"}, 32'(o_grant), 32'(og));
    endtask

    initial begin
        // Test 1: reset values, idle inputs.
        reset   = 1'b1;
        o_ready = 1'b1;
        i_valid = 4'b1111;
        i_last  = '0;
        i_data  = '0;
        #1;
        check("t1.ready_in_reset", 32'(i_ready), 32'h0);
        tick();
        check("t1.rst.o_valid", 32'(o_valid), 32'h0);
        check("t1.rst.o_data",  32'(o_data),  32'h0);
        check("t1.rst.o_last",  32'(o_last),  32'h0);
        check("t1.rst.o_grant", 32'(o_grant), 32'h0);
        i_valid = '0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1.idle.o_valid", 32'(o_valid), 32'h0);
            check("t1.idle.i_ready", 32'(i_ready), 32'h0);
            check("t1.idle.o_grant", 32'(o_grant), 32'h0);
        end

        // Test 2: all requesters valid, single-beat packets -> 10,11,12,13,10.
        do_reset();
        i_valid = 4'b1111;
        i_last  = 4'b1111;
        i_data  = 32'h13121110;
        #1;
        check("t2.first_ready", 32'(i_ready), 32'h1);
        check("t2.no_output_yet", 32'(o_valid), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2.o_valid", 32'(o_valid), 32'h1);
            check("t2.o_data",  32'(o_data),  32'h10 + 32'(i % 4));
            check("t2.o_grant", 32'(o_grant), 32'(i % 4));
            if (i == 4) begin
                i_valid = '0;
            end
        end
        tick();
        check("t2.drain.o_valid", 32'(o_valid), 32'h0);

        // Test 3: req1 sends a 3-beat packet while req0 and req2 are also valid.
        do_reset();
        step("t3.e1", 4'b0001, 4'b0001, 32'h0000000F, 4'b0001, 1'b1, 8'h0F, 1'b1, 2'd0);
`ifdef STREAM_ARB_PKT_LOCK_EN
        step("t3.e2", 4'b0111, 4'b0101, 32'h00C2B1A0, 4'b0010, 1'b1, 8'hB1, 1'b0, 2'd1);
        step("t3.e3", 4'b0111, 4'b0101, 32'h00C2B2A0, 4'b0010, 1'b1, 8'hB2, 1'b0, 2'd1);
        step("t3.e4", 4'b0111, 4'b0111, 32'h00C2B3A0, 4'b0010, 1'b1, 8'hB3, 1'b1, 2'd1);
        step("t3.e5", 4'b0101, 4'b0111, 32'h00C2B3A0, 4'b0100, 1'b1, 8'hC2, 1'b1, 2'd2);
        step("t3.e6", 4'b0001, 4'b0111, 32'h00C2B3A0, 4'b0001, 1'b1, 8'hA0, 1'b1, 2'd0);
`else
        step("t3.e2", 4'b0111, 4'b0101, 32'h00C2B1A0, 4'b0010, 1'b1, 8'hB1, 1'b0, 2'd1);
        step("t3.e3", 4'b0111, 4'b0101, 32'h00C2B2A0, 4'b0100, 1'b1, 8'hC2, 1'b1, 2'd2);
        step("t3.e4", 4'b0111, 4'b0111, 32'h00C2B3A0, 4'b0001, 1'b1, 8'hA0, 1'b1, 2'd0);
        step("t3.e5", 4'b0101, 4'b0111, 32'h00C2B3A0, 4'b0100, 1'b1, 8'hC2, 1'b1, 2'd2);
        step("t3.e6", 4'b0001, 4'b0111, 32'h00C2B3A0, 4'b0001, 1'b1, 8'hA0, 1'b1, 2'd0);
`endif
        step("t3.e7", 4'b0000, 4'b0111, 32'h00C2B3A0, 4'b0000, 1'b0, 8'hA0, 1'b1, 2'd0);

        // Test 4: output stall holds the registered beat and blocks all requesters.
        do_reset();
        step("t4.load", 4'b0001, 4'b0001, 32'h000000A8, 4'b0001, 1'b1, 8'hA8, 1'b1, 2'd0);
        o_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step("t4.stall", 4'b0010, 4'b0010, 32'h0000B9A8, 4'b0000, 1'b1, 8'hA8, 1'b1, 2'd0);
        end
        o_ready = 1'b1;
        step("t4.resume", 4'b0010, 4'b0010, 32'h0000B9A8, 4'b0010, 1'b1, 8'hB9, 1'b1, 2'd1);
        step("t4.drain",  4'b0000, 4'b0000, 32'h0000B9A8, 4'b0000, 1'b0, 8'hB9, 1'b1, 2'd1);

        // Test 5: req0 drops valid mid-packet while req3 waits.
        do_reset();
        step("t5.e1", 4'b1001, 4'b1000, 32'hD3000050, 4'b0001, 1'b1, 8'h50, 1'b0, 2'd0);
`ifdef STREAM_ARB_PKT_LOCK_EN
        step("t5.gap1", 4'b1000, 4'b1000, 32'hD3000050, 4'b0001, 1'b0, 8'h50, 1'b0, 2'd0);
        step("t5.gap2", 4'b1000, 4'b1000, 32'hD3000050, 4'b0001, 1'b0, 8'h50, 1'b0, 2'd0);
`else
        step("t5.gap1", 4'b1000, 4'b1000, 32'hD3000050, 4'b1000, 1'b1, 8'hD3, 1'b1, 2'd3);
        step("t5.gap2", 4'b1000, 4'b1000, 32'hD3000050, 4'b1000, 1'b1, 8'hD3, 1'b1, 2'd3);
`endif
        step("t5.e4", 4'b1001, 4'b1001, 32'hD3000052, 4'b0001, 1'b1, 8'h52, 1'b1, 2'd0);
        step("t5.e5", 4'b1000, 4'b1001, 32'hD3000052, 4'b1000, 1'b1, 8'hD3, 1'b1, 2'd3);
        step("t5.e6", 4'b0000, 4'b0000, 32'hD3000052, 4'b0000, 1'b0, 8'hD3, 1'b1, 2'd3);

        // Test 6: reset mid-packet with a pending output beat.
        do_reset();
        step("t6.e1", 4'b0001, 4'b0000, 32'h00000060, 4'b0001, 1'b1, 8'h60, 1'b0, 2'd0);
        o_ready = 1'b0;
        reset   = 1'b1;
        #1;
        check("t6.ready_in_reset", 32'(i_ready), 32'h0);
        tick();
        check("t6.o_valid", 32'(o_valid), 32'h0);
        check("t6.o_data",  32'(o_data),  32'h0);
        check("t6.o_grant", 32'(o_grant), 32'h0);
        check("t6.lock",    32'(dut.lock), 32'h0);
        check("t6.ptr",     32'(dut.ptr),  32'h0);
        reset   = 1'b0;
        o_ready = 1'b1;
        step("t6.e2", 4'b1010, 4'b1010, 32'h73007100, 4'b0010, 1'b1, 8'h71, 1'b1, 2'd1);
        step("t6.e3", 4'b0000, 4'b0000, 32'h73007100, 4'b0000, 1'b0, 8'h71, 1'b1, 2'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
